// File: rtl/code_lock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : code_lock_pkg
//  Brief    : State encodings and timer-width helper for the code lock.
//  Revision : 1.0 - initial release
// ============================================================================
package code_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_ERROR   = 3'd3,
        ST_LOCKOUT = 3'd4
    } lock_state_e;

    // One timer serves all three durations, so size it for the largest.
    function automatic int timer_width(input int open_cycles,
                                       input int lock_cycles,
                                       input int timeout);
        int m;
        m = open_cycles;
        if (lock_cycles > m) m = lock_cycles;
        if (timeout > m)     m = timeout;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/code_lock_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : code_lock_ctrl_if
//  Brief    : Keypad/config inputs and status outputs of the code lock.
//  Revision : 1.0 - initial release
// ============================================================================
interface code_lock_ctrl_if #(
    parameter int DIGITS = 2,
    parameter int DW     = 2
);
    logic [DW-1:0]        digit;
    logic                 enter;
    logic                 cfg_we;
    logic [DIGITS*DW-1:0] cfg_code;
    logic                 open;
    logic                 err;
    logic                 locked;
    logic [3:0]           fail_cnt;
    logic [2:0]           state_o;

    modport master (
        output digit, enter, cfg_we, cfg_code,
        input  open, err, locked, fail_cnt, state_o
    );

    modport slave (
        input  digit, enter, cfg_we, cfg_code,
        output open, err, locked, fail_cnt, state_o
    );
endinterface
`default_nettype wire

// File: rtl/code_lock_timer.sv
`default_nettype none
// ============================================================================
//  Module   : code_lock_timer
//  Brief    : Loadable down-counter; done is high while the count is zero.
//  Revision : 1.0 - initial release
// ============================================================================
module code_lock_timer #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    output logic                  done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/code_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : code_lock_ctrl
//  Brief    : Digit-entry code lock with retry limit, lockout and timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module code_lock_ctrl
    import code_lock_pkg::*;
#(
    parameter int                   DIGITS      = 2,
    parameter int                   DW          = 2,
    parameter logic [DIGITS*DW-1:0] RESET_CODE  = 4'b0111,
    parameter int                   MAX_TRIES   = 3,
    parameter int                   OPEN_CYCLES = 50,
    parameter int                   LOCK_CYCLES = 1000,
    parameter int                   TIMEOUT     = 255
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    code_lock_ctrl_if.slave bus
);

    localparam int CW = DIGITS * DW;
    localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TW = timer_width(OPEN_CYCLES, LOCK_CYCLES, TIMEOUT);

    localparam logic [TW-1:0] c_open_load = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] c_lock_load = TW'(LOCK_CYCLES - 1);
    localparam logic [TW-1:0] c_tmo_load  = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] c_last_pos  = PW'(DIGITS - 1);

    lock_state_e   r_state, state_nxt;
    logic [CW-1:0] r_code, code_nxt;
    logic [PW-1:0] r_pos, pos_nxt;
    logic          r_mis, mis_nxt;
    logic [3:0]    r_fail, fail_nxt;
    logic          r_open, r_err, r_locked;

    logic          w_open_nxt, w_err_nxt, w_locked_nxt;
    logic          w_tmr_load;
    logic [TW-1:0] w_tmr_val;
    logic          w_tmr_done;
    logic [DW-1:0] w_code_digits [DIGITS];
    logic [DW-1:0] w_exp_digit;
    logic          w_mis_all;
    logic          w_last;
    logic [4:0]    w_fail_inc;
    logic          w_to_lock;

    // First digit lives in the MSBs of the stored code.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digits
        assign w_code_digits[g] = r_code[(DIGITS-1-g)*DW +: DW];
    end

    assign w_exp_digit = w_code_digits[r_pos];
    assign w_mis_all   = r_mis | (bus.digit != w_exp_digit);
    assign w_last      = (r_pos == c_last_pos);
    assign w_fail_inc  = {1'b0, r_fail} + 5'd1;
    assign w_to_lock   = (w_fail_inc >= 5'(MAX_TRIES));

    code_lock_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .done     (w_tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_code   <= RESET_CODE;
            r_pos    <= '0;
            r_mis    <= 1'b0;
            r_fail   <= '0;
            r_open   <= 1'b0;
            r_err    <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= state_nxt;
            r_code   <= code_nxt;
            r_pos    <= pos_nxt;
            r_mis    <= mis_nxt;
            r_fail   <= fail_nxt;
            r_open   <= w_open_nxt;
            r_err    <= w_err_nxt;
            r_locked <= w_locked_nxt;
        end
    end

    always_comb begin
        state_nxt  = r_state;
        code_nxt   = r_code;
        pos_nxt    = r_pos;
        mis_nxt    = r_mis;
        fail_nxt   = r_fail;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            ST_IDLE, ST_ENTRY: begin
                if (bus.enter) begin
                    if (w_last) begin
                        // Full code received: the sticky flag includes this digit.
                        pos_nxt    = '0;
                        mis_nxt    = 1'b0;
                        w_tmr_load = 1'b1;
                        if (!w_mis_all) begin
                            state_nxt = ST_OPEN;
                            fail_nxt  = '0;
                            w_tmr_val = c_open_load;
                        end else if (!w_to_lock) begin
                            state_nxt = ST_ERROR;
                            fail_nxt  = w_fail_inc[3:0];
                        end else begin
                            state_nxt = ST_LOCKOUT;
                            fail_nxt  = w_fail_inc[3:0];
                            w_tmr_val = c_lock_load;
                        end
                    end else begin
                        state_nxt  = ST_ENTRY;
                        pos_nxt    = r_pos + PW'(1);
                        mis_nxt    = w_mis_all;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = c_tmo_load;
                    end
                end else if (r_state == ST_ENTRY && w_tmr_done) begin
                    state_nxt = ST_IDLE;
                    pos_nxt   = '0;
                    mis_nxt   = 1'b0;
                end
            end
            ST_OPEN: begin
                if (bus.cfg_we) begin
                    code_nxt = bus.cfg_code;
                end
                if (w_tmr_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ERROR: begin
                state_nxt = ST_IDLE;
            end
            ST_LOCKOUT: begin
                if (w_tmr_done) begin
                    state_nxt = ST_IDLE;
                    fail_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                pos_nxt   = '0;
                mis_nxt   = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_open_nxt   = (state_nxt == ST_OPEN);
        w_err_nxt    = (state_nxt == ST_ERROR);
        w_locked_nxt = (state_nxt == ST_LOCKOUT);
    end

    assign bus.open     = r_open;
    assign bus.err      = r_err;
    assign bus.locked   = r_locked;
    assign bus.fail_cnt = r_fail;
    assign bus.state_o  = r_state;

endmodule
`default_nettype wire
